// File: rtl/mc_control_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, FSM states,
// ALU operation codes and the bundled control word.
package mc_control_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam int TIMER_W = 8;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_WB_R     = 4'd3,
    S_EXEC_I   = 4'd4,
    S_WB_I     = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       bne;
    logic [1:0] alu_op;
    logic       pc_write;
    logic       ir_write;
    logic       trap;
  } ctrl_t;

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Wait-state counter for the data-memory states; flags when the allowed
// number of wait cycles has been used up.
module mc_wait_timer
  import mc_control_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  logic [TIMER_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (count_en) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expired = (count_q == TIMER_W'(MEM_WAIT_MAX));

endmodule

// File: rtl/mc_control.sv
// Multi-cycle instruction sequencer: walks FETCH/DECODE/execute states,
// stalls on data memory with a timeout trap and counts retired instructions.
module mc_control
  import mc_control_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  OpCode,
  input  logic        mem_ready,
  output logic        RegDst,
  output logic        AluSrc,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        Branch,
  output logic        Jump,
  output logic        Bne,
  output logic [1:0]  ALUOp,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        trap,
  output logic [31:0] instret
);

  state_t      state_q;
  state_t      state_nxt;
  logic [5:0]  op_q;
  logic [5:0]  op_dec;
  ctrl_t       ctrl_q;
  logic [31:0] instret_q;
  logic        in_mem;
  logic        timer_clear;
  logic        timer_en;
  logic        timer_expired;
  logic        pc_write;

  // Control word for a state; the MEM_WR commit depends on mem_ready and is
  // added combinationally outside this table.
  function automatic ctrl_t decode_ctrl(input state_t s, input logic [5:0] op);
    ctrl_t c;
    c = '0;
    unique case (s)
      S_FETCH:    c.ir_write = 1'b1;
      S_DECODE:   c = '0;
      S_EXEC_R: begin
        c.reg_dst = 1'b1;
        c.alu_op  = ALU_FUNCT;
      end
      S_WB_R: begin
        c.reg_dst   = 1'b1;
        c.alu_op    = ALU_FUNCT;
        c.reg_write = 1'b1;
        c.pc_write  = 1'b1;
      end
      S_EXEC_I:   c.alu_src = 1'b1;
      S_WB_I: begin
        c.alu_src   = 1'b1;
        c.reg_write = 1'b1;
        c.pc_write  = 1'b1;
      end
      S_MEM_ADDR: c.alu_src = 1'b1;
      S_MEM_RD: begin
        c.alu_src  = 1'b1;
        c.mem_read = 1'b1;
      end
      S_WB_MEM: begin
        c.alu_src    = 1'b1;
        c.mem_read   = 1'b1;
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
        c.pc_write   = 1'b1;
      end
      S_MEM_WR: begin
        c.alu_src   = 1'b1;
        c.mem_write = 1'b1;
      end
      S_BRANCH: begin
        c.alu_op   = ALU_SUB;
        c.branch   = (op == OP_BEQ);
        c.bne      = (op != OP_BEQ);
        c.pc_write = 1'b1;
      end
      S_JUMP: begin
        c.jump     = 1'b1;
        c.pc_write = 1'b1;
      end
      S_TRAP:     c.trap = 1'b1;
      default:    c.trap = 1'b1;
    endcase
    return c;
  endfunction

  assign in_mem      = (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign timer_clear = (state_q == S_MEM_ADDR);
  assign timer_en    = in_mem && !mem_ready;

  mc_wait_timer #(
    .MEM_WAIT_MAX (MEM_WAIT_MAX)
  ) u_wait_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (timer_clear),
    .count_en (timer_en),
    .expired  (timer_expired)
  );

  // The opcode is only on the bus during DECODE; later states use the latch.
  assign op_dec = (state_q == S_DECODE) ? OpCode : op_q;

  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        unique case (OpCode)
          OP_R:           state_nxt = S_EXEC_R;
          OP_ADDI:        state_nxt = S_EXEC_I;
          OP_LW, OP_SW:   state_nxt = S_MEM_ADDR;
          OP_BEQ, OP_BNE: state_nxt = S_BRANCH;
          OP_J:           state_nxt = S_JUMP;
          default:        state_nxt = S_TRAP;
        endcase
      end
      S_EXEC_R:   state_nxt = S_WB_R;
      S_WB_R:     state_nxt = S_FETCH;
      S_EXEC_I:   state_nxt = S_WB_I;
      S_WB_I:     state_nxt = S_FETCH;
      S_MEM_ADDR: state_nxt = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (mem_ready)          state_nxt = S_WB_MEM;
        else if (timer_expired) state_nxt = S_TRAP;
      end
      S_WB_MEM:   state_nxt = S_FETCH;
      S_MEM_WR: begin
        if (mem_ready)          state_nxt = S_FETCH;
        else if (timer_expired) state_nxt = S_TRAP;
      end
      S_BRANCH:   state_nxt = S_FETCH;
      S_JUMP:     state_nxt = S_FETCH;
      S_TRAP:     state_nxt = S_TRAP;
      default:    state_nxt = S_TRAP;
    endcase
  end

  assign pc_write = ctrl_q.pc_write || ((state_q == S_MEM_WR) && mem_ready);

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      ctrl_q    <= decode_ctrl(S_FETCH, '0);
      instret_q <= '0;
    end else begin
      state_q <= state_nxt;
      ctrl_q  <= decode_ctrl(state_nxt, op_dec);
      if (state_q == S_DECODE) begin
        op_q <= OpCode;
      end
      if (pc_write) begin
        instret_q <= instret_q + 32'd1;
      end
    end
  end

  assign RegDst   = ctrl_q.reg_dst;
  assign AluSrc   = ctrl_q.alu_src;
  assign MemtoReg = ctrl_q.mem_to_reg;
  assign RegWrite = ctrl_q.reg_write;
  assign MemRead  = ctrl_q.mem_read;
  assign MemWrite = ctrl_q.mem_write;
  assign Branch   = ctrl_q.branch;
  assign Jump     = ctrl_q.jump;
  assign Bne      = ctrl_q.bne;
  assign ALUOp    = ctrl_q.alu_op;
  assign PCWrite  = pc_write;
  assign IRWrite  = ctrl_q.ir_write;
  assign trap     = ctrl_q.trap;
  assign instret  = instret_q;

endmodule

// File: tb/tb_mc_control.sv
// Directed plus randomized bench for mc_control against a per-instruction
// cycle-sequence reference model.
module tb_mc_control;

  localparam int MAXW = 15;

  localparam logic [5:0] T_R = 6'b000000, T_ADDI = 6'b001000, T_LW = 6'b100011;
  localparam logic [5:0] T_SW = 6'b101011, T_BEQ = 6'b000100, T_BNE = 6'b000101;
  localparam logic [5:0] T_J = 6'b000010, T_ILL = 6'b111111;

  // Observed word: {RegDst,AluSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,Jump,Bne,ALUOp,PCWrite,IRWrite,trap}
  localparam logic [13:0] C_REGDST = 14'h2000, C_ALUSRC = 14'h1000, C_MEM2REG = 14'h0800;
  localparam logic [13:0] C_REGWR  = 14'h0400, C_MEMRD  = 14'h0200, C_MEMWR   = 14'h0100;
  localparam logic [13:0] C_BRANCH = 14'h0080, C_JUMP   = 14'h0040, C_BNE     = 14'h0020;
  localparam logic [13:0] C_FUNCT  = 14'h0010, C_SUB    = 14'h0008, C_PC      = 14'h0004;
  localparam logic [13:0] C_IR     = 14'h0002, C_TRAP   = 14'h0001;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  OpCode;
  logic        mem_ready;
  logic        RegDst, AluSrc, MemtoReg, RegWrite, MemRead, MemWrite;
  logic        Branch, Jump, Bne, PCWrite, IRWrite, trap;
  logic [1:0]  ALUOp;
  logic [31:0] instret;
  logic [13:0] obs;

  int          total = 0;
  int          bad = 0;
  logic [31:0] instret_m = 0;
  logic [5:0]  legal [7];

  always #5 clk = ~clk;

  mc_control #(.MEM_WAIT_MAX(MAXW)) dut (
    .clk(clk), .reset(reset), .OpCode(OpCode), .mem_ready(mem_ready),
    .RegDst(RegDst), .AluSrc(AluSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch), .Jump(Jump),
    .Bne(Bne), .ALUOp(ALUOp), .PCWrite(PCWrite), .IRWrite(IRWrite),
    .trap(trap), .instret(instret)
  );

  assign obs = {RegDst, AluSrc, MemtoReg, RegWrite, MemRead, MemWrite,
                Branch, Jump, Bne, ALUOp, PCWrite, IRWrite, trap};

  task automatic check_vec(input string tag, input logic [13:0] o, input logic [13:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Called just after a negedge; reset is sampled at the following posedge.
  task automatic do_reset(input logic mr);
    reset = 1'b0;
    mem_ready = mr;
    OpCode = 6'($urandom);
    @(negedge clk);
    reset = 1'b1;
    instret_m = 0;
    #1;
    check_vec("reset_ctrl", obs, C_IR);
    check32("reset_instret", instret, 32'd0);
  endtask

  // Expected per-cycle control words for one instruction, from FETCH onward.
  task automatic run_instr(input logic [5:0] op, input int waits, input int stop_after,
                           output logic trapped);
    logic [13:0] q [$];
    logic [13:0] mw;
    logic        memop;
    trapped = 1'b0;
    memop = (op == T_LW) || (op == T_SW);
    q.push_back(C_IR);
    q.push_back(14'h0);
    case (op)
      T_R: begin
        q.push_back(C_REGDST | C_FUNCT);
        q.push_back(C_REGDST | C_FUNCT | C_REGWR | C_PC);
      end
      T_ADDI: begin
        q.push_back(C_ALUSRC);
        q.push_back(C_ALUSRC | C_REGWR | C_PC);
      end
      T_LW, T_SW: begin
        q.push_back(C_ALUSRC);
        mw = (op == T_LW) ? (C_ALUSRC | C_MEMRD) : (C_ALUSRC | C_MEMWR);
        if (waits > MAXW) begin
          for (int i = 0; i <= MAXW; i++) q.push_back(mw);
          trapped = 1'b1;
        end else begin
          for (int i = 0; i < waits; i++) q.push_back(mw);
          if (op == T_LW) begin
            q.push_back(mw);
            q.push_back(C_ALUSRC | C_MEMRD | C_MEM2REG | C_REGWR | C_PC);
          end else begin
            q.push_back(mw | C_PC);
          end
        end
      end
      T_BEQ:   q.push_back(C_SUB | C_BRANCH | C_PC);
      T_BNE:   q.push_back(C_SUB | C_BNE | C_PC);
      T_J:     q.push_back(C_JUMP | C_PC);
      default: trapped = 1'b1;
    endcase
    for (int k = 0; k < q.size(); k++) begin
      if (stop_after >= 0 && k >= stop_after) break;
      OpCode = (k == 1) ? op : 6'($urandom);
      if (memop && k >= 3 && k < 3 + waits) mem_ready = 1'b0;
      else if (memop && k == 3 + waits)     mem_ready = 1'b1;
      else                                  mem_ready = 1'($urandom);
      #1;
      check_vec($sformatf("ctrl_op%b_w%0d_c%0d", op, waits, k), obs, q[k]);
      check32($sformatf("instret_op%b_c%0d", op, k), instret, instret_m);
      if (q[k][2]) instret_m = instret_m + 32'd1;
      @(negedge clk);
    end
  endtask

  task automatic check_trap(input int n);
    for (int i = 0; i < n; i++) begin
      OpCode = 6'($urandom);
      mem_ready = 1'($urandom);
      #1;
      check_vec($sformatf("trap_hold_%0d", i), obs, C_TRAP);
      check32("trap_instret", instret, instret_m);
      @(negedge clk);
    end
  endtask

  initial begin
    logic tr;
    legal = '{T_R, T_ADDI, T_LW, T_SW, T_BEQ, T_BNE, T_J};
    reset = 1'b0;
    OpCode = '0;
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    do_reset(1'b0);

    run_instr(T_R, 0, -1, tr);
    #1 check32("instret_after_r", instret, 32'd1);
    run_instr(T_LW, 3, -1, tr);
    #1 check32("instret_after_lw", instret, 32'd2);

    run_instr(T_SW, 1000, -1, tr);
    check_trap(5);
    do_reset(1'b1);

    run_instr(T_BEQ, 0, -1, tr);
    run_instr(T_BNE, 0, -1, tr);
    run_instr(T_J, 0, -1, tr);
    #1 check32("instret_after_branches", instret, 32'd3);

    run_instr(T_SW, MAXW, -1, tr);
    run_instr(T_LW, MAXW, -1, tr);
    run_instr(T_LW, MAXW + 1, -1, tr);
    check_trap(3);
    do_reset(1'b0);

    run_instr(T_ILL, 0, -1, tr);
    check_trap(100);
    do_reset(1'b0);

    force dut.instret_q = 32'hFFFF_FFFF;
    #1 release dut.instret_q;
    instret_m = 32'hFFFF_FFFF;
    run_instr(T_J, 0, -1, tr);
    #1 check32("instret_wrap", instret, 32'd0);

    run_instr(T_LW, 10, 5, tr);
    do_reset(1'b1);

    for (int i = 0; i < 30; i++) begin
      int w;
      w = ($urandom_range(0, 7) == 0) ? MAXW : int'($urandom_range(0, 4));
      run_instr(legal[$urandom_range(0, 6)], w, -1, tr);
    end
    #1 check32("instret_final", instret, instret_m);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_control.md
# mc_control

Multi-cycle control unit: the controller end of the datapath control interface. Consumes `OpCode` from the datapath and sequences one instruction over 3–5+ cycles. Drives the datapath select/enable set (`RegDst`…`ALUOp`) plus `PCWrite`/`IRWrite`, which a multi-cycle datapath needs. Stalls on a variable-latency data memory via `mem_ready`, with timeout, and counts retired instructions.

## Interface
- `MEM_WAIT_MAX`, 15: maximum wait-state count in a memory state before trapping (1..255).
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-low reset.
- `OpCode` in 6: `Instruction[31:26]` from the datapath. Sampled in DECODE only.
- `mem_ready` in 1: data memory done. Sampled in MEM_RD/MEM_WR only.
- `RegDst`, `AluSrc`, `MemtoReg`, `RegWrite`, `MemRead`, `MemWrite`, `Branch`, `Jump`, `Bne` out 1 each: datapath controls.
- `ALUOp` out 2: 00 add, 01 sub, 10 funct-decoded.
- `PCWrite` out 1: commit; PC updates this edge.
- `IRWrite` out 1: latch instruction register.
- `trap` out 1: illegal opcode or memory timeout; sticky.
- `instret` out 32: retired-instruction count.

## Operation
- Decisions after DECODE use `op_q`, the opcode latched in DECODE.
- Opcodes: R 000000, addi 001000, lw 100011, sw 101011, beq 000100, bne 000101, j 000010. Any other value is illegal.
- Outputs decode from state only, except `PCWrite` in MEM_WR (=`mem_ready`). Unlisted signals are 0.
  - FETCH: `IRWrite`. Next: DECODE.
  - DECODE: none. Next: EXEC_R, EXEC_I, MEM_ADDR (lw/sw), BRANCH, JUMP, or TRAP.
  - EXEC_R: `RegDst`, `ALUOp`=10. Next: WB_R.
  - WB_R: `RegDst`, `ALUOp`=10, `RegWrite`, `PCWrite`. Next: FETCH.
  - EXEC_I: `AluSrc`. Next: WB_I.
  - WB_I: `AluSrc`, `RegWrite`, `PCWrite`. Next: FETCH.
  - MEM_ADDR: `AluSrc`. Next: MEM_RD if lw, else MEM_WR.
  - MEM_RD: `AluSrc`, `MemRead`. Next: WB_MEM when `mem_ready`.
  - WB_MEM: `AluSrc`, `MemRead`, `MemtoReg`, `RegWrite`, `PCWrite`. Next: FETCH.
  - MEM_WR: `AluSrc`, `MemWrite`, `PCWrite`=`mem_ready`. Next: FETCH when `mem_ready`.
  - BRANCH: `ALUOp`=01, `Branch` if beq else `Bne`, `PCWrite`. Next: FETCH.
  - JUMP: `Jump`, `PCWrite`. Next: FETCH.
  - TRAP: `trap` only. Stays until reset.
- Wait timer (8-bit):
  - Cleared on entry to MEM_RD/MEM_WR.
  - Increments each cycle there with `mem_ready`=0.
  - If `mem_ready`=0 and the timer equals `MEM_WAIT_MAX`, go to TRAP. At most `MEM_WAIT_MAX`+1 cycles are spent in the state.
  - `mem_ready`=1 in that same cycle wins: normal exit, no trap.
- `instret`: +1 on every edge where `PCWrite`=1. Wraps from FFFFFFFF to 0.

## Timing
- Reset: `reset`=0 at an edge sets state=FETCH, `op_q`=0, timer=0, `instret`=0. Dominates all other inputs in any state, including mid-memory-wait and TRAP.
- Outputs after reset (state FETCH): `IRWrite`=1; every other output 0; `instret`=0.
- Latency with zero wait states (`mem_ready` high on first sample): R/addi/sw 4 cycles, lw 5, beq/bne/j 3. Each memory wait cycle adds 1.
- `PCWrite` is asserted exactly once per retired instruction, in its final cycle. Never asserted in TRAP.
- `mem_ready` high outside MEM_RD/MEM_WR has no effect.

## Structure
- Package `mc_control_pkg`: opcode localparams, 4-bit state encoding, `ALUOp` codes (ADD/SUB/FUNCT).
- Sub-module `mc_wait_timer` (clear, count-enable, `MEM_WAIT_MAX` compare → `expired`).
- Top level holds the state register, `op_q`, `instret`, and output decode.

## Test plan
- R-type (000000) after reset, `mem_ready` tied 1 → states FETCH, DECODE, EXEC_R, WB_R. `RegWrite`&`RegDst` in cycle 4 only; `instret`=1.
- lw with `mem_ready` low 3 cycles → MEM_RD held 4 cycles, `MemRead` high throughout. WB_MEM asserts `MemtoReg`,`RegWrite`,`PCWrite`. Total 8 cycles.
- sw with `mem_ready` never high, `MEM_WAIT_MAX`=15 → TRAP after 16 MEM_WR cycles. `MemWrite` drops, `trap`=1, `instret` unchanged.
- beq then bne then j (3 cycles each) → `Branch`, `Bne`, `Jump` respectively with `ALUOp`=01 for branches. `instret`=3 after 9 cycles.
- Illegal opcode 111111 → TRAP on cycle 3 and held for 100 cycles. `reset` low one edge → FETCH, `IRWrite`=1, `trap`=0.
- `instret` preloaded near wrap via force to FFFFFFFF, then one instruction retires → 00000000. `reset` low during MEM_RD wait → FETCH next cycle, `MemRead`=0.
